// File: rtl/grid_line_clear.sv
// grid_line_clear: line-clear engine for the dual-port playfield grid memory.
// Scans rows bottom-up; each full row is removed by shifting the rows above it
// down by one and clearing row 0, then the same row is re-scanned.
// Port A is write-only, port B is read-only with one cycle of read latency.
// Optional macro GRID_EMPTY_ROW_EXIT_EN: an all-empty scanned row ends the pass.

module grid_line_clear #(
  parameter int unsigned GRID_W     = 10,
  parameter int unsigned GRID_H     = 20,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      lines_cleared_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_a_o,
  output logic [DATA_WIDTH-1:0] mem_data_a_o,
  output logic                  mem_we_a_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_b_o,
  input  logic [DATA_WIDTH-1:0] mem_q_b_i
);

  localparam int unsigned ColW = $clog2(GRID_W + 1);
  localparam int unsigned RowW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  localparam logic [ColW-1:0]       ColOne    = ColW'(1);
  localparam logic [ColW-1:0]       LastCol   = ColW'(GRID_W - 1);
  localparam logic [ColW-1:0]       WrapCol   = ColW'(GRID_W);
  localparam logic [RowW-1:0]       RowOne    = RowW'(1);
  localparam logic [RowW-1:0]       RowTwo    = RowW'(2);
  localparam logic [RowW-1:0]       BottomRow = RowW'(GRID_H - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne   = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      CntOne    = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StCheck,
    StShift,
    StClear,
    StFinish
  } state_e;

  state_e                  state_q, state_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [RowW-1:0]         dst_q, dst_d;
  logic [ColW-1:0]         col_q, col_d;
  logic                    full_q, full_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;

  logic q_nz;
  logic row_full;
  logic row_last;
  logic shift_wr;

  function automatic logic [ADDR_WIDTH-1:0] row_base(input logic [RowW-1:0] row);
    return ADDR_WIDTH'(32'(row) * GRID_W);
  endfunction

  assign q_nz = |mem_q_b_i;
  // In CHECK the last column of the row is on q_b, so fold it in combinationally.
  assign row_full = full_q & q_nz;

`ifdef GRID_EMPTY_ROW_EXIT_EN
  logic empty_q, empty_d;
  logic row_empty;
  assign row_empty = empty_q & ~q_nz;
  assign row_last  = (row_q == '0) | row_empty;
`else
  assign row_last  = (row_q == '0);
`endif

  // Shift writes lag reads by one cycle; column 0 of a shifted row is read-only.
  assign shift_wr        = (state_q == StShift) && (col_q != '0);
  assign mem_we_a_o      = shift_wr || (state_q == StClear);
  assign mem_data_a_o    = shift_wr ? mem_q_b_i : '0;
  assign mem_addr_a_o    = addr_a_q;
  assign mem_addr_b_o    = addr_b_q;
  assign busy_o          = (state_q != StIdle) && (state_q != StFinish);
  assign done_o          = (state_q == StFinish);
  assign lines_cleared_o = cnt_q;

  // Next-state logic: sequencing of scan, shift and clear phases plus pointers.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    dst_d    = dst_q;
    col_d    = col_q;
    full_d   = full_q;
    cnt_d    = cnt_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
`ifdef GRID_EMPTY_ROW_EXIT_EN
    empty_d  = empty_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StScan;
          row_d    = BottomRow;
          col_d    = '0;
          full_d   = 1'b1;
          cnt_d    = '0;
          addr_b_d = row_base(BottomRow);
`ifdef GRID_EMPTY_ROW_EXIT_EN
          empty_d  = 1'b1;
`endif
        end
      end
      StScan: begin
        // Data for column col_q-1 is returning this cycle.
        if (col_q != '0) begin
          full_d  = full_q & q_nz;
`ifdef GRID_EMPTY_ROW_EXIT_EN
          empty_d = empty_q & ~q_nz;
`endif
        end
        if (col_q == LastCol) begin
          state_d = StCheck;
          col_d   = '0;
        end else begin
          col_d    = col_q + ColOne;
          addr_b_d = addr_b_q + AddrOne;
        end
      end
      StCheck: begin
        if (row_full) begin
          col_d = '0;
          if (row_q == '0) begin
            // Row 0 has nothing above it: clearing alone removes it.
            state_d  = StClear;
            addr_a_d = '0;
          end else begin
            state_d  = StShift;
            dst_d    = row_q;
            addr_b_d = row_base(row_q - RowOne);
            addr_a_d = row_base(row_q);
          end
        end else if (row_last) begin
          state_d = StFinish;
        end else begin
          state_d  = StScan;
          row_d    = row_q - RowOne;
          col_d    = '0;
          full_d   = 1'b1;
          addr_b_d = row_base(row_q - RowOne);
`ifdef GRID_EMPTY_ROW_EXIT_EN
          empty_d  = 1'b1;
`endif
        end
      end
      StShift: begin
        if (col_q == WrapCol) begin
          col_d = '0;
          if (dst_q == RowOne) begin
            state_d  = StClear;
            dst_d    = '0;
            addr_a_d = '0;
          end else begin
            dst_d    = dst_q - RowOne;
            addr_b_d = row_base(dst_q - RowTwo);
            addr_a_d = row_base(dst_q - RowOne);
          end
        end else begin
          col_d = col_q + ColOne;
          if (col_q != LastCol) addr_b_d = addr_b_q + AddrOne;
          if (col_q != '0)      addr_a_d = addr_a_q + AddrOne;
        end
      end
      StClear: begin
        if (col_q == LastCol) begin
          // Re-scan the same row: the rows above have collapsed onto it.
          state_d  = StScan;
          col_d    = '0;
          full_d   = 1'b1;
          addr_b_d = row_base(row_q);
          cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
`ifdef GRID_EMPTY_ROW_EXIT_EN
          empty_d  = 1'b1;
`endif
        end else begin
          col_d    = col_q + ColOne;
          addr_a_d = addr_a_q + AddrOne;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      row_q    <= '0;
      dst_q    <= '0;
      col_q    <= '0;
      full_q   <= 1'b0;
      cnt_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
`ifdef GRID_EMPTY_ROW_EXIT_EN
      empty_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      dst_q    <= dst_d;
      col_q    <= col_d;
      full_q   <= full_d;
      cnt_q    <= cnt_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
`ifdef GRID_EMPTY_ROW_EXIT_EN
      empty_q  <= empty_d;
`endif
    end
  end

endmodule

// File: tb/tb_grid_line_clear.sv
// Bench for grid_line_clear: behavioural grid memory, row-level reference model,
// directed cases plus randomized grids.

module tb_grid_line_clear;

  localparam int W        = 10;
  localparam int H        = 20;
  localparam int MaxLines = 7;
  localparam int Limit    = 20000;
`ifdef GRID_EMPTY_ROW_EXIT_EN
  localparam bit ExitEn = 1'b1;
`else
  localparam bit ExitEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, we;
  logic [2:0] lines;
  logic [7:0] addr_a, data_a, addr_b;
  logic [7:0] q_b;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load_req = 1'b0;
  logic [7:0] exp_grid [H][W];

  int checks = 0;
  int errors = 0;
  int pass_done_k, pass_pulses, pass_we;

  grid_line_clear #(
    .GRID_W(10), .GRID_H(20), .DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_W(3)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .busy_o         (busy),
    .done_o         (done),
    .lines_cleared_o(lines),
    .mem_addr_a_o   (addr_a),
    .mem_data_a_o   (data_a),
    .mem_we_a_o     (we),
    .mem_addr_b_o   (addr_b),
    .mem_q_b_i      (q_b)
  );

  always #5 clk = ~clk;

  // Dual-port grid memory: 1-cycle read, port-A write forwarded on address match.
  always @(posedge clk) begin
    q_b <= (we && addr_a == addr_b) ? data_a : mem[addr_b];
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (we) begin
      mem[addr_a] <= data_a;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_row(input int r);
    logic [127:0] v = '0;
    for (int c = 0; c < W; c++) v[c*8 +: 8] = mem[r*W + c];
    return v;
  endfunction

  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] v = '0;
    for (int c = 0; c < W; c++) v[c*8 +: 8] = exp_grid[r][c];
    return v;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic fill_row(input int r, input logic [7:0] v);
    for (int c = 0; c < W; c++) img[r*W + c] = v;
  endtask

  // Copy img into memory and into the model's starting grid.
  task automatic load_grid();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_grid[r][c] = img[r*W + c];
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Row-level model: remove full rows bottom-up, re-testing the row that
  // received the collapsed contents; also tallies the expected cycle cost.
  task automatic run_model(output int exp_lines, output int exp_cycles);
    int r;
    bit full, empty;
    exp_lines  = 0;
    exp_cycles = 0;
    r = H - 1;
    while (1) begin
      exp_cycles += W + 1;
      full  = 1'b1;
      empty = 1'b1;
      for (int c = 0; c < W; c++) begin
        if (exp_grid[r][c] == 8'h00) full = 1'b0;
        else empty = 1'b0;
      end
      if (full) begin
        exp_cycles += r * (W + 1) + W;
        for (int k = r; k > 0; k--)
          for (int c = 0; c < W; c++) exp_grid[k][c] = exp_grid[k-1][c];
        for (int c = 0; c < W; c++) exp_grid[0][c] = 8'h00;
        if (exp_lines < MaxLines) exp_lines++;
      end else if (r == 0 || (ExitEn && empty)) begin
        break;
      end else begin
        r--;
      end
    end
    exp_cycles += 1;
  endtask

  // Pulse start, then count cycles to done (bounded); optionally re-pulse
  // start at cycle extra_at while busy.
  task automatic run_pass(input int extra_at);
    int k;
    pass_done_k = -1;
    pass_pulses = 0;
    pass_we     = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    k = 1;
    check_eq("busy_after_start", busy, 1'b1);
    while (k < Limit) begin
      start = (k == extra_at);
      @(negedge clk);
      k++;
      if (we) pass_we++;
      if (done) begin
        pass_done_k = k;
        break;
      end
    end
    start = 1'b0;
    if (pass_done_k > 0) begin
      pass_pulses = 1;
      check_eq("busy_at_done", busy, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) pass_pulses++;
    end
  endtask

  task automatic do_test(input string tag, input int extra_at);
    int exp_lines, exp_cycles;
    run_model(exp_lines, exp_cycles);
    run_pass(extra_at);
    check_eq({tag, "_latency"}, pass_done_k, exp_cycles);
    check_eq({tag, "_lines"}, lines, exp_lines);
    check_eq({tag, "_done_pulses"}, pass_pulses, 1);
    for (int r = 0; r < H; r++)
      check_eq($sformatf("%s_row%0d", tag, r), mem_row(r), exp_row(r));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_we"}, we, 1'b0);
    check_eq({tag, "_lines"}, lines, 3'd0);
    check_eq({tag, "_addr_a"}, addr_a, 8'd0);
    check_eq({tag, "_data_a"}, data_a, 8'd0);
    check_eq({tag, "_addr_b"}, addr_b, 8'd0);
  endtask

  initial begin
    int n;
    clear_img();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Empty grid: fixed latency, no writes at all.
    clear_img();
    load_grid();
    do_test("empty", 0);
    check_eq("empty_latency_abs", pass_done_k, ExitEn ? 12 : 221);
    check_eq("empty_no_writes", pass_we, 0);

    // Single full bottom row with one cell above it.
    clear_img();
    fill_row(19, 8'h03);
    img[18*W] = 8'h05;
    load_grid();
    do_test("one_line", 0);
    check_eq("one_line_row19_abs", mem_row(19), 128'h05);

    // Four stacked full rows.
    clear_img();
    for (int r = 16; r < 20; r++) fill_row(r, 8'h07);
    load_grid();
    do_test("four_lines", 0);
    check_eq("four_lines_abs", lines, 3'd4);

    // Full rows separated by a partial row, with a stray start mid-pass.
    clear_img();
    fill_row(19, 8'h09);
    fill_row(17, 8'h0a);
    img[18*W]     = 8'h01;
    img[18*W + 1] = 8'h02;
    load_grid();
    do_test("split", 5);
    check_eq("split_row19_abs", mem_row(19), 128'h0201);
    check_eq("split_lines_abs", lines, 3'd2);

    // Ten full rows: counter saturates, all rows still removed.
    clear_img();
    for (int r = 10; r < 20; r++) fill_row(r, 8'(r + 1));
    load_grid();
    do_test("saturate", 0);

    // Row 0 full on its own: removed by the clear phase only.
    clear_img();
    fill_row(0, 8'h44);
    for (int r = 1; r < 20; r++) img[r*W + 3] = 8'h11;
    load_grid();
    do_test("top_row", 0);

    // Reset during the shift phase, then a fresh pass over what is left.
    clear_img();
    fill_row(19, 8'h03);
    img[18*W] = 8'h05;
    load_grid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!we && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("reset_reached_shift", we, 1'b1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_grid[r][c] = mem[r*W + c];
    do_test("after_reset", 0);

    // Randomized grids.
    for (int t = 0; t < 20; t++) begin
      clear_img();
      for (int r = 0; r < H; r++) begin
        case ($urandom_range(0, 5))
          0: fill_row(r, 8'h00);
          1: for (int c = 0; c < W; c++) img[r*W + c] = 8'($urandom_range(1, 255));
          2: begin
            for (int c = 0; c < W; c++) img[r*W + c] = 8'($urandom_range(1, 255));
            img[r*W + $urandom_range(0, W - 1)] = 8'h00;
          end
          default:
            for (int c = 0; c < W; c++)
              img[r*W + c] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        endcase
      end
      load_grid();
      do_test($sformatf("rand%0d", t), ($urandom_range(0, 1) == 1) ? 7 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_line_clear.md
Name: grid_line_clear

Overview:
Line-clear engine that acts as the client of the dual-port playfield grid memory. On a start pulse it scans the grid bottom-up and finds rows whose cells are all non-zero. Each full row is removed by shifting every row above it down one, and the top row is cleared. It reports the number of lines cleared to the game controller and the score logic.

Parameters:
GRID_W, 10, columns per row (cells)
GRID_H, 20, rows; GRID_W*GRID_H <= 2**ADDR_WIDTH
DATA_WIDTH, 8, cell width; 0 = empty, non-zero = occupied (colour)
ADDR_WIDTH, 8, grid memory address width
CNT_W, 3, width of lines_cleared

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
start  input  1  one-cycle request to run a clear pass
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse when the pass completes
lines_cleared  output  CNT_W  full rows removed in the last pass
mem_addr_a  output  ADDR_WIDTH  write address to grid memory port A
mem_data_a  output  DATA_WIDTH  write data to port A
mem_we_a  output  1  port A write enable
mem_addr_b  output  ADDR_WIDTH  read address to grid memory port B
mem_q_b  input  DATA_WIDTH  port B read data, valid 1 cycle after mem_addr_b

Behaviour:
- Reset (async, any state): state IDLE; busy, done, mem_we_a = 0; lines_cleared, mem_addr_a, mem_data_a, mem_addr_b = 0. Grid contents are not touched. A reset mid-shift leaves a partially shifted grid; that is acceptable.
- Cell address = row*GRID_W + col. Row 0 is the top row; row GRID_H-1 is the bottom row.
- Port A is used only for writes and port B only for reads. Memory read latency is exactly 1 cycle. The memory forwards port-A write data to q_b on an address match.
- IDLE: start=1 -> busy=1, lines_cleared=0, cur_row=GRID_H-1, go to SCAN. A start received while busy is ignored.
- SCAN: issue addr_b for cols 0..GRID_W-1 on consecutive cycles. AND together (q_b != 0) as data returns. Then one CHECK cycle, so a row costs GRID_W+1 cycles.
- CHECK:
  - Row full -> go to SHIFT with dst=cur_row.
  - Row not full and cur_row==0 -> FINISH.
  - Otherwise cur_row-1, then SCAN.
- SHIFT: for each col, read (dst-1,col) on port B at cycle t; write q_b to (dst,col) on port A at t+1. Reads and writes are pipelined, so a row costs GRID_W+1 cycles. When a row is finished, dst-1; when dst reaches 0, go to CLEAR.
- CLEAR: write 0 to row 0 cols 0..GRID_W-1, one per cycle (GRID_W cycles). Then increment lines_cleared, saturating at 2**CNT_W-1, and return to SCAN of the same cur_row so that collapsed rows are re-checked.
- FINISH: busy=0 and done=1 for one cycle, then IDLE. lines_cleared holds its value until the next accepted start.
- mem_we_a is high only on SHIFT write cycles and CLEAR cycles. mem_addr_a and mem_data_a are don't-care when mem_we_a=0, but are held stable.
- A full row 0 is cleared by CLEAR alone; there is no SHIFT because dst is already 0.

Optional Feature:
GRID_EMPTY_ROW_EXIT_EN
- Defined: a scanned row whose cells are all zero ends the pass immediately (CHECK -> FINISH). This relies on the game rule that no occupied cell sits above an empty row.
- Undefined: the scan always continues to row 0.

Test Plan:
1. Empty grid (W=10, H=20), start -> done exactly 221 cycles after start (20 rows × 11 cycles, plus FINISH), lines_cleared=0, mem_we_a never high.
2. Row 19 all 3, row 18 col0=5 -> lines_cleared=1; row 19 = {5,0,...,0}; rows 0..18 all 0.
3. Rows 16..19 all 7 -> lines_cleared=4, whole grid 0, done pulses once.
4. Rows 19 and 17 full, row 18 = {1,2,0,...} -> lines_cleared=2; row 19 = {1,2,0,...}; the other rows are 0.
5. Start asserted while busy -> ignored, single done. Reset low during SHIFT -> all outputs 0 immediately. After release, a new start completes normally.
6. With GRID_EMPTY_ROW_EXIT_EN defined, empty grid -> done 12 cycles after start, lines_cleared=0.
